// File: rtl/sy_ppl_reg_state_mw_if.sv
// Dispatch-lookup and wakeup bundle for the multi-lane register ready scoreboard.
// The master drives dispatch/wakeup requests; the slave returns per-lane source readiness.
interface sy_ppl_reg_state_mw_if #(
    parameter int PHY_REG_WTH = 6,
    parameter int DISP_W      = 2,
    parameter int WB_W        = 5,
    parameter int LAT_W       = 3
);
    logic [DISP_W-1:0]             disp_valid_i;
    logic [DISP_W*PHY_REG_WTH-1:0] disp_rs1_idx_i;
    logic [DISP_W*PHY_REG_WTH-1:0] disp_rs2_idx_i;
    logic [DISP_W*PHY_REG_WTH-1:0] disp_rs3_idx_i;
    logic [DISP_W-1:0]             disp_rs1_is_fp_i;
    logic [DISP_W-1:0]             disp_rs2_is_fp_i;
    logic [DISP_W-1:0]             disp_rdst_en_i;
    logic [DISP_W-1:0]             disp_rdst_is_fp_i;
    logic [DISP_W*PHY_REG_WTH-1:0] disp_rdst_idx_i;
    logic [DISP_W*LAT_W-1:0]       disp_lat_i;
    logic [WB_W-1:0]               wb_en_i;
    logic [WB_W-1:0]               wb_is_fp_i;
    logic [WB_W*PHY_REG_WTH-1:0]   wb_idx_i;
    logic [DISP_W-1:0]             rs1_state_o;
    logic [DISP_W-1:0]             rs2_state_o;
    logic [DISP_W-1:0]             rs3_state_o;

    modport master (
        output disp_valid_i, disp_rs1_idx_i, disp_rs2_idx_i, disp_rs3_idx_i,
        output disp_rs1_is_fp_i, disp_rs2_is_fp_i, disp_rdst_en_i, disp_rdst_is_fp_i,
        output disp_rdst_idx_i, disp_lat_i, wb_en_i, wb_is_fp_i, wb_idx_i,
        input  rs1_state_o, rs2_state_o, rs3_state_o
    );

    modport slave (
        input  disp_valid_i, disp_rs1_idx_i, disp_rs2_idx_i, disp_rs3_idx_i,
        input  disp_rs1_is_fp_i, disp_rs2_is_fp_i, disp_rdst_en_i, disp_rdst_is_fp_i,
        input  disp_rdst_idx_i, disp_lat_i, wb_en_i, wb_is_fp_i, wb_idx_i,
        output rs1_state_o, rs2_state_o, rs3_state_o
    );
endinterface

// File: rtl/sy_ppl_reg_state_mw.sv
// Multi-lane GPR/FP physical-register ready scoreboard with same-cycle wakeup bypass
// and intra-group dependency masking. Define SY_REG_STATE_DELAY_WAKE_EN for countdown self-wakeup.
module sy_ppl_reg_state_mw #(
    parameter int PHY_REG     = 64,
    parameter int PHY_REG_WTH = 6,
    parameter int DISP_W      = 2,
    parameter int WB_W        = 5,
    parameter int LAT_W       = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    sy_ppl_reg_state_mw_if.slave  bus
);

    localparam int CLS = 2;  // class 0 = GPR, class 1 = FP

    typedef logic [CLS-1:0][PHY_REG-1:0] map_t;

    map_t state_r;
    map_t state_nxt_s;
    map_t wb_hit_s;
    map_t wake_s;
    map_t alloc_s;
    logic [DISP_W-1:0][CLS-1:0][PHY_REG-1:0] lane_alloc_s;
    logic [DISP_W-1:0][CLS-1:0][PHY_REG-1:0] conflict_s;
    logic [DISP_W-1:0] rs1_s;
    logic [DISP_W-1:0] rs2_s;
    logic [DISP_W-1:0] rs3_s;

    function automatic logic src_ready(input map_t st, input map_t wk, input map_t cf,
                                       input logic cls, input logic [PHY_REG_WTH-1:0] idx);
        return (st[cls][idx] | wk[cls][idx]) & ~cf[cls][idx];
    endfunction

    // Decode all wakeup ports into a per-register hit map (multiple hits simply OR).
    always_comb begin
        wb_hit_s = '0;
        for (int w = 0; w < WB_W; w++) begin
            wb_hit_s[bus.wb_is_fp_i[w]][bus.wb_idx_i[w*PHY_REG_WTH +: PHY_REG_WTH]] =
                wb_hit_s[bus.wb_is_fp_i[w]][bus.wb_idx_i[w*PHY_REG_WTH +: PHY_REG_WTH]] | bus.wb_en_i[w];
        end
    end

    // Per-lane allocation maps, plus the union of allocations by strictly older lanes.
    always_comb begin
        lane_alloc_s = '0;
        conflict_s   = '0;
        for (int d = 0; d < DISP_W; d++) begin
            lane_alloc_s[d][bus.disp_rdst_is_fp_i[d]][bus.disp_rdst_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]] =
                bus.disp_valid_i[d] & bus.disp_rdst_en_i[d];
        end
        for (int d = 1; d < DISP_W; d++) begin
            conflict_s[d] = conflict_s[d-1] | lane_alloc_s[d-1];
        end
        alloc_s = conflict_s[DISP_W-1] | lane_alloc_s[DISP_W-1];
        // GPR0 is hardwired ready, so an older lane writing it never creates a dependency.
        for (int d = 0; d < DISP_W; d++) begin
            conflict_s[d][0][0] = 1'b0;
        end
    end

`ifdef SY_REG_STATE_DELAY_WAKE_EN
    logic [CLS-1:0][PHY_REG-1:0][LAT_W-1:0] cnt_r;
    logic [CLS-1:0][PHY_REG-1:0][LAT_W-1:0] cnt_nxt_s;
    logic [CLS-1:0][PHY_REG-1:0][LAT_W-1:0] alloc_lat_s;
    map_t cnt_wake_s;

    // Latency to load per register; the youngest allocating lane wins a duplicate.
    always_comb begin
        alloc_lat_s = '0;
        for (int d = 0; d < DISP_W; d++) begin
            alloc_lat_s[bus.disp_rdst_is_fp_i[d]][bus.disp_rdst_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]] =
                (bus.disp_valid_i[d] & bus.disp_rdst_en_i[d]) ? bus.disp_lat_i[d*LAT_W +: LAT_W] :
                alloc_lat_s[bus.disp_rdst_is_fp_i[d]][bus.disp_rdst_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]];
        end
    end

    // Countdown next value and the scheduled wake that fires when a countdown reaches 1.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        cnt_wake_s = '0;
        for (int c = 0; c < CLS; c++) begin
            for (int r = 0; r < PHY_REG; r++) begin
                cnt_wake_s[c][r] = (cnt_r[c][r] == LAT_W'(1));
                if (flush_i || wb_hit_s[c][r]) begin
                    cnt_nxt_s[c][r] = '0;
                end else if (alloc_s[c][r]) begin
                    cnt_nxt_s[c][r] = alloc_lat_s[c][r];
                end else if (cnt_r[c][r] != LAT_W'(0)) begin
                    cnt_nxt_s[c][r] = cnt_r[c][r] - LAT_W'(1);
                end else begin
                    cnt_nxt_s[c][r] = cnt_r[c][r];
                end
            end
        end
    end

    // Countdown registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

    // Wake sources: explicit writeback or an expiring countdown.
    always_comb begin
        wake_s = wb_hit_s | cnt_wake_s;
    end
`else
    // Wake sources: explicit writeback only.
    always_comb begin
        wake_s = wb_hit_s;
    end
`endif

    // Ready-bit update: flush beats wake, wake beats allocation, otherwise hold.
    always_comb begin
        if (flush_i) begin
            state_nxt_s = '1;
        end else begin
            state_nxt_s = wake_s | (state_r & ~alloc_s);
        end
        state_nxt_s[0][0] = 1'b1;
    end

    // Ready-bit registers; reset marks everything ready.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= '1;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Same-cycle source lookups; rs3 is always an FP source.
    always_comb begin
        rs1_s = '0;
        rs2_s = '0;
        rs3_s = '0;
        for (int d = 0; d < DISP_W; d++) begin
            rs1_s[d] = src_ready(state_r, wake_s, conflict_s[d], bus.disp_rs1_is_fp_i[d],
                                 bus.disp_rs1_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]);
            rs2_s[d] = src_ready(state_r, wake_s, conflict_s[d], bus.disp_rs2_is_fp_i[d],
                                 bus.disp_rs2_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]);
            rs3_s[d] = src_ready(state_r, wake_s, conflict_s[d], 1'b1,
                                 bus.disp_rs3_idx_i[d*PHY_REG_WTH +: PHY_REG_WTH]);
        end
    end

    assign bus.rs1_state_o = rs1_s;
    assign bus.rs2_state_o = rs2_s;
    assign bus.rs3_state_o = rs3_s;

endmodule
